// File: rtl/rmii_rx_slot_ctrl_if.sv
// Receive-slot controller bus bundle.
// Groups the receive-writer side (rx_*), the memory write gate (mem_we),
// the descriptor consumer handshake (desc_*) and the statistics counters.
//   master : receive writer + descriptor consumer + stats reader (drives rx_*, desc_ack)
//   slave  : rmii_rx_slot_ctrl (drives offset, mem_we, desc_*, counters)
interface rmii_rx_slot_ctrl_if #(
    parameter int unsigned L = 13
);
    logic [L-1:0]  rx_addr;
    logic          rx_we;
    logic          rx_rdy;
    logic [L-1:0]  rx_count;
    logic [L-1:0]  offset;
    logic          mem_we;
    logic          desc_valid;
    logic [L-1:0]  desc_base;
    logic [L-1:0]  desc_len;
    logic          desc_ack;
    logic [15:0]   pkt_cnt;
    logic [15:0]   drop_cnt;

    modport master (
        output rx_addr, rx_we, rx_rdy, rx_count, desc_ack,
        input  offset, mem_we, desc_valid, desc_base, desc_len, pkt_cnt, drop_cnt
    );

    modport slave (
        input  rx_addr, rx_we, rx_rdy, rx_count, desc_ack,
        output offset, mem_we, desc_valid, desc_base, desc_len, pkt_cnt, drop_cnt
    );
endinterface

// File: rtl/rmii_rx_slot_ctrl.sv
// Receive-buffer slot manager for the RMII receive path.
// Packet memory is a ring of 2^NB slots of 2^S bytes. The writer is steered to
// the current write slot via offset; mem_we gates its writes so they never leave
// that slot. Finished packets are validated (oversize / runt / ring full) and
// good ones are queued as (base, length) descriptors for a consumer.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : rx_addr/rx_we/rx_rdy/rx_count in, offset/mem_we out,
//                     desc_valid/desc_base/desc_len out, desc_ack in,
//                     pkt_cnt/drop_cnt saturating statistics out
module rmii_rx_slot_ctrl #(
    parameter int unsigned S       = 11,
    parameter int unsigned NB      = 2,
    parameter int unsigned MIN_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    rmii_rx_slot_ctrl_if.slave  bus
);
    localparam int unsigned L          = S + NB;
    localparam int unsigned NSLOT      = 1 << NB;
    localparam logic [NB-1:0] USED_MAX = '1;
    localparam logic [L-1:0] SLOT_BYTES = L'(2 ** S);
    localparam logic [L-1:0] MIN_BYTES  = L'(MIN_LEN);
    localparam logic [15:0]  CNT_MAX    = 16'hFFFF;

    logic [NB-1:0] wr_slot, wr_slot_n;
    logic [NB-1:0] rd_slot, rd_slot_n;
    logic [NB-1:0] used, used_n;
    logic          oflow, oflow_n;
    logic [L-1:0]  len_q [NSLOT];
    logic [L-1:0]  len_n [NSLOT];
    logic [15:0]   pkt_cnt_q, pkt_cnt_n;
    logic [15:0]   drop_cnt_q, drop_cnt_n;

    logic in_slot, ack, oversize, runt, full, commit, drop;

    // Only the slot-index bits of the write address matter here.
    logic unused_rx_addr;
    assign unused_rx_addr = ^bus.rx_addr[S-1:0];

    // Packet-end evaluation, ring pointer and statistics next state.
    always_comb begin
        wr_slot_n  = wr_slot;
        rd_slot_n  = rd_slot;
        used_n     = used;
        oflow_n    = oflow;
        len_n      = len_q;
        pkt_cnt_n  = pkt_cnt_q;
        drop_cnt_n = drop_cnt_q;

        in_slot  = (bus.rx_addr[L-1:S] == wr_slot);
        ack      = bus.desc_ack && (used != '0);
        oversize = oflow || (bus.rx_count > SLOT_BYTES);
        runt     = (bus.rx_count < MIN_BYTES);
        // A same-cycle pop frees the slot a full ring needs.
        full     = (used == USED_MAX) && !ack;
        commit   = bus.rx_rdy && !oversize && !runt && !full;
        drop     = bus.rx_rdy && !commit;

        // Sticky until end of packet; catches wrap past the last slot too.
        if (bus.rx_rdy) begin
            oflow_n = 1'b0;
        end else if (bus.rx_we && !in_slot) begin
            oflow_n = 1'b1;
        end

        if (commit) begin
            len_n[wr_slot] = bus.rx_count;
            wr_slot_n      = wr_slot + NB'(1);
            if (pkt_cnt_q != CNT_MAX) begin
                pkt_cnt_n = pkt_cnt_q + 16'd1;
            end
        end

        if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_n = drop_cnt_q + 16'd1;
        end

        if (ack) begin
            rd_slot_n = rd_slot + NB'(1);
        end

        used_n = used + NB'(commit) - NB'(ack);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_slot    <= '0;
            rd_slot    <= '0;
            used       <= '0;
            oflow      <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < int'(NSLOT); i++) begin
                len_q[i] <= '0;
            end
        end else begin
            wr_slot    <= wr_slot_n;
            rd_slot    <= rd_slot_n;
            used       <= used_n;
            oflow      <= oflow_n;
            pkt_cnt_q  <= pkt_cnt_n;
            drop_cnt_q <= drop_cnt_n;
            len_q      <= len_n;
        end
    end

    // Outputs: mem_we is the only combinational one; the rest come straight from registers.
    assign bus.mem_we     = bus.rx_we && !oflow && in_slot;
    assign bus.offset     = {wr_slot, {S{1'b0}}};
    assign bus.desc_valid = (used != '0);
    assign bus.desc_base  = {rd_slot, {S{1'b0}}};
    assign bus.desc_len   = len_q[rd_slot];
    assign bus.pkt_cnt    = pkt_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_rmii_rx_slot_ctrl.sv
// Testbench for rmii_rx_slot_ctrl: directed scenarios plus randomized packets,
// checked against a queue-based model of the descriptor ring.
module tb_rmii_rx_slot_ctrl;
    localparam int unsigned S       = 11;
    localparam int unsigned NB      = 2;
    localparam int unsigned L       = S + NB;
    localparam int unsigned MIN_LEN = 64;
    localparam int SLOT  = 1 << S;
    localparam int NSLOT = 1 << NB;
    localparam int MEM   = 1 << L;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rmii_rx_slot_ctrl_if #(.L(L)) bus ();

    rmii_rx_slot_ctrl #(.S(S), .NB(NB), .MIN_LEN(MIN_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: pending descriptors as a FIFO queue.
    typedef struct {
        int base;
        int len;
    } desc_t;

    desc_t q[$];
    int    m_wr;
    bit    m_oflow;
    int    m_pkt;
    int    m_drop;
    int    checks;
    int    failures;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr    = 0;
        m_oflow = 1'b0;
        m_pkt   = 0;
        m_drop  = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".offset"}, 32'(bus.offset), 32'(m_wr * SLOT));
        chk({tag, ".desc_valid"}, 32'(bus.desc_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".desc_base"}, 32'(bus.desc_base), 32'(q[0].base));
            chk({tag, ".desc_len"}, 32'(bus.desc_len), 32'(q[0].len));
        end
        chk({tag, ".pkt_cnt"}, 32'(bus.pkt_cnt), 32'(m_pkt));
        chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    // One clock: drive inputs (caller is just after posedge), check mem_we at negedge,
    // advance the model across the posedge, then check registered outputs.
    task automatic cycle(input bit we, input int addr, input bit rdy, input int count,
                         input bit ack, input string tag);
        bit exp_we, eff_ack, ok;
        int a;
        a = addr % MEM;
        bus.rx_we    = we;
        bus.rx_addr  = L'(a);
        bus.rx_rdy   = rdy;
        bus.rx_count = L'(count);
        bus.desc_ack = ack;
        @(negedge clk);
        exp_we = we && !m_oflow && ((a / SLOT) == m_wr);
        if (we || rdy) chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(exp_we));

        eff_ack = ack && (q.size() != 0);
        if (rdy) begin
            ok = !(m_oflow || count > SLOT) && !(count < int'(MIN_LEN))
                 && !(q.size() == NSLOT - 1 && !eff_ack);
            if (ok) begin
                q.push_back('{base: m_wr * SLOT, len: count});
                m_wr = (m_wr + 1) % NSLOT;
                if (m_pkt < 65535) m_pkt++;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
            m_oflow = 1'b0;
        end else if (we && (a / SLOT) != m_wr) begin
            m_oflow = 1'b1;
        end
        if (eff_ack) void'(q.pop_front());

        @(posedge clk);
        #1;
        if (rdy || ack) check_state(tag);
    endtask

    function automatic bit rand_pct(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // Writer streams nbytes from the model's write slot, then pulses rx_rdy.
    task automatic send_pkt(input int nbytes, input int count, input int ack_pct,
                            input bit ack_at_rdy, input string tag);
        int start;
        start = m_wr * SLOT;
        for (int i = 0; i < nbytes; i++) begin
            cycle(1'b1, start + i, 1'b0, 0, rand_pct(ack_pct), tag);
        end
        cycle(1'b0, 0, 1'b1, count, ack_at_rdy, tag);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 16;
        while (q.size() != 0 && budget > 0) begin
            cycle(1'b0, 0, 1'b0, 0, 1'b1, tag);
            budget--;
        end
        chk({tag, ".drain_budget"}, 32'(q.size()), 32'd0);
    endtask

    task automatic goto_slot(input int target, input string tag);
        for (int i = 0; i < NSLOT && m_wr != target; i++) begin
            send_pkt(64, 64, 0, 1'b1, tag);
        end
        chk({tag, ".goto_slot"}, 32'(m_wr), 32'(target));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst          = 1'b1;
        bus.rx_we    = 1'b0;
        bus.rx_addr  = '0;
        bus.rx_rdy   = 1'b0;
        bus.rx_count = '0;
        bus.desc_ack = 1'b0;
        model_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset.desc_base", 32'(bus.desc_base), 32'd0);
        chk("reset.desc_len", 32'(bus.desc_len), 32'd0);
        chk("reset.mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) cycle(1'b0, 0, 1'b0, 0, 1'b0, "idle");
        check_state("idle");

        // Single 100-byte packet, then pop it.
        send_pkt(100, 100, 0, 1'b0, "p100");
        chk("p100.offset_abs", 32'(bus.offset), 32'd2048);
        cycle(1'b0, 0, 1'b0, 0, 1'b1, "p100_ack");

        // Fill the ring, hit ring-full, then commit with a same-cycle ack.
        for (int i = 0; i < 3; i++) send_pkt(64, 64, 0, 1'b0, "fill");
        chk("fill.offset_abs", 32'(bus.offset), 32'd0);
        drain("fill_drain");
        goto_slot(0, "realign");
        for (int i = 0; i < 3; i++) send_pkt(64, 64, 0, 1'b0, "fill3");
        chk("fill3.offset_abs", 32'(bus.offset), 32'd6144);
        send_pkt(64, 64, 0, 1'b0, "full_drop");
        chk("full_drop.offset_abs", 32'(bus.offset), 32'd6144);
        chk("full_drop.base_abs", 32'(bus.desc_base), 32'd0);
        send_pkt(64, 64, 0, 1'b1, "full_ackcommit");
        chk("full_ackcommit.offset_abs", 32'(bus.offset), 32'd0);
        chk("full_ackcommit.used", 32'(q.size()), 32'd3);
        drain("d1");

        // Runt boundary.
        send_pkt(63, 63, 0, 1'b0, "runt63");
        send_pkt(64, 64, 0, 1'b0, "len64");
        send_pkt(0, 0, 0, 1'b0, "runt0");
        send_pkt(2048, 2048, 0, 1'b0, "len2048");
        drain("d2");

        // Oversize from slot 3 wraps into slot 0 and must be gated.
        goto_slot(3, "to3");
        drain("d3");
        send_pkt(2056, 2056, 0, 1'b0, "oversize");
        send_pkt(100, 100, 0, 1'b0, "after_ovf");
        drain("d4");

        // Reset in the middle of a packet in slot 1.
        goto_slot(1, "to1");
        for (int i = 0; i < 50; i++) cycle(1'b1, SLOT + i, 1'b0, 0, 1'b0, "mid");
        rst = 1'b1;
        bus.rx_we = 1'b0;
        #1;
        model_reset();
        check_state("midrst");
        chk("midrst.mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(80, 80, 0, 1'b0, "post_rst");
        drain("d5");

        // Randomized packets with random consumer behaviour.
        for (int p = 0; p < 80; p++) begin
            int kind, n, c, pct;
            kind = int'($urandom_range(9));
            pct  = int'($urandom_range(40));
            if (kind == 0) begin
                n = int'($urandom_range(63));
                c = n;
            end else if (kind == 1) begin
                n = 2049 + int'($urandom_range(10));
                c = n;
            end else if (kind == 2) begin
                n = 70;
                c = 2049 + int'($urandom_range(100));
            end else begin
                n = 64 + int'($urandom_range(150));
                c = n;
            end
            send_pkt(n, c, pct, rand_pct(50), "rand");
            for (int g = 0; g < int'($urandom_range(3)); g++) begin
                cycle(1'b0, 0, 1'b0, 0, rand_pct(30), "gap");
            end
        end
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
